// File: rtl/rr_grant_scheduler_pkg.sv
// rr_grant_scheduler_pkg: shared sizes and state encoding for the round-robin grant scheduler
package rr_grant_scheduler_pkg;
  localparam int N_REQ = 16;
  localparam int IDX_W = 4;
  localparam int HOLD_W = 8;
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    TURN  = 2'd2
  } state_t;
endpackage

// File: rtl/rr_grant_scheduler_decode.sv
// grant_decode4: 4-to-16 one-hot decoder gated by an enable
module grant_decode4 #(
  parameter int UUID = 0
) (
  input  logic [3:0]  i_idx,
  input  logic        i_en,
  output logic [15:0] o_onehot
);
  assign o_onehot = {15'b0, i_en} << i_idx;
endmodule

// File: rtl/rr_grant_scheduler.sv
// rr_grant_scheduler: 16-way round-robin owner scheduler with hold limit and turnaround cycle
module rr_grant_scheduler
  import rr_grant_scheduler_pkg::*;
#(
  parameter int    UUID     = 0,
  parameter string NAME     = "",
  parameter int    MAX_HOLD = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_REQ-1:0] req,
  input  logic             done,
  output logic [N_REQ-1:0] grant,
  output logic [IDX_W-1:0] grant_idx,
  output logic             grant_valid,
  output logic             timeout
);
  function automatic logic [IDX_W-1:0] rr_pick(input logic [N_REQ-1:0] r, input logic [IDX_W-1:0] p);
    logic [2*N_REQ-1:0] dbl;
    logic [N_REQ-1:0]   rot;
    logic [IDX_W-1:0]   f;
    dbl = {r, r} >> p;
    rot = dbl[N_REQ-1:0];
    f = '0;
    for (int i = N_REQ - 1; i >= 0; i--) f = rot[i] ? IDX_W'(i) : f;
    return f + p;
  endfunction

  state_t             r_state, w_state_nxt;
  logic [IDX_W-1:0]   r_ptr, w_ptr_nxt, r_owner, w_owner_nxt, w_win;
  logic [HOLD_W-1:0]  r_hold, w_hold_nxt;
  logic               r_timeout, w_timeout_nxt, w_lim, w_exit, w_any;

  assign w_any  = |req;
  assign w_win  = rr_pick(req, r_ptr);
  assign w_lim  = (MAX_HOLD != 0) && (r_hold == HOLD_W'(MAX_HOLD));
  assign w_exit = done || !req[r_owner] || w_lim;

  // next-state: arbitrate in IDLE/TURN, hold or release in GRANT; timeout only for a pure hold-limit exit
  always_comb begin
    w_state_nxt   = IDLE;
    w_ptr_nxt     = r_ptr;
    w_owner_nxt   = r_owner;
    w_hold_nxt    = r_hold;
    w_timeout_nxt = 1'b0;
    case (r_state)
      GRANT: begin
        w_state_nxt   = w_exit ? TURN : GRANT;
        w_timeout_nxt = w_exit && !done && req[r_owner];
        w_hold_nxt    = (w_exit || &r_hold) ? r_hold : r_hold + 1'b1;
      end
      IDLE, TURN: begin
        w_state_nxt = w_any ? GRANT : IDLE;
        w_owner_nxt = w_any ? w_win : r_owner;
        w_ptr_nxt   = w_any ? w_win + 1'b1 : r_ptr;
        w_hold_nxt  = w_any ? HOLD_W'(1) : r_hold;
      end
      default: ;
    endcase
  end

  // state register; reset drops ownership at once with no turnaround
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= IDLE;
      r_ptr     <= '0;
      r_owner   <= '0;
      r_hold    <= '0;
      r_timeout <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_ptr     <= w_ptr_nxt;
      r_owner   <= w_owner_nxt;
      r_hold    <= w_hold_nxt;
      r_timeout <= w_timeout_nxt;
    end
  end

  assign grant_valid = (r_state == GRANT);
  assign grant_idx   = grant_valid ? r_owner : '0;
  assign timeout     = r_timeout;

  grant_decode4 #(.UUID(UUID ^ 32'h0000_0D34)) u_dec (
    .i_idx    (grant_idx),
    .i_en     (grant_valid),
    .o_onehot (grant)
  );
endmodule

// File: doc/rr_grant_scheduler.md
# rr_grant_scheduler

Round-robin scheduler that shares one 16-way resource, such as a bus, register-file write port or peripheral slot, among 16 requesters. It selects one owner at a time and drives the owner's 4-bit index. It also drives the same choice as a one-hot grant vector produced by a 4-to-16 decoder. Ownership is held until the owner signals completion, drops its request, or exceeds a hold limit. One mandatory turnaround cycle separates consecutive owners.

## Interface
- UUID, 0, instance identifier XORed into sub-module UUIDs.
- NAME, "", instance name string.
- MAX_HOLD, 8, maximum consecutive GRANT cycles per ownership; 0 = unlimited; range 0–255.

- clk  in  1  single clock, all state rising-edge.
- rst  in  1  synchronous, active-high reset.
- req  in  16  request per requester; bit i = requester i.
- done  in  1  current owner finishes its transaction this cycle.
- grant  out  16  one-hot grant, decoded from grant_idx; all zero when grant_valid=0.
- grant_idx  out  4  index of current owner; 0 when grant_valid=0.
- grant_valid  out  1  high while in GRANT.
- timeout  out  1  one-cycle pulse when ownership was forcibly ended by MAX_HOLD.

## Operation
- State machine states:
  - IDLE: no owner, arbitrate.
  - GRANT: owner active.
  - TURN: turnaround; outputs zero, arbitrate.
- Arbitration, evaluated in IDLE and TURN:
  - Scan req starting at ptr, ascending, wrapping 15→0.
  - The first set bit wins. If it is bit w, next state is GRANT with owner=w, ptr ← (w+1) mod 16.
  - If req=0, next state is IDLE. ptr is unchanged.
- GRANT exits to TURN at the end of the cycle on any of the following:
  - done=1, or
  - req[owner]=0, or
  - MAX_HOLD≠0 and hold_cnt==MAX_HOLD.
- hold_cnt, 8 bits:
  - Loaded with 1 on entry to GRANT.
  - Increments each further GRANT cycle.
  - Saturates, never wraps.
- timeout is set to 1 for the TURN cycle only if the exit was caused solely by the hold limit. Exit by done or by a dropped request yields timeout=0, including when that coincides with hold expiry.
- Requests arriving mid-GRANT are not considered until TURN. There is no preemption.
- Reset values: state=IDLE, ptr=0, owner=0, hold_cnt=0, grant=0, grant_idx=0, grant_valid=0, timeout=0.
- Reset mid-operation drops ownership immediately at the next edge. No TURN cycle is inserted.

## Timing
- All outputs are registered. There is no combinational path from req or done to any output.
- Request latency: req seen in IDLE at cycle N → grant_valid, grant and grant_idx are valid at N+1.
- Release: an exit condition at cycle M → TURN at M+1, with outputs zero. The next owner, if any request is pending at M+1, is granted at M+2.
- Back-to-back ownership always has exactly one zero cycle between owners, even when the same requester wins again.
- MAX_HOLD=K: grant_valid is high for at most K consecutive cycles per ownership.
- timeout asserts in the cycle grant_valid falls, for one cycle.

## Structure
- Shared package/header holds:
  - N_REQ=16 and IDX_W=4.
  - State encodings IDLE=2'd0, GRANT=2'd1, TURN=2'd2; 2'd3 is illegal and recovers to IDLE.
- Natural sub-module: grant_decode4, the 4-to-16 one-hot decoder. It takes grant_idx and is ANDed with grant_valid.
- The priority scan is a rotate-by-ptr, find-first-set, un-rotate function kept in the top module.

## Test plan
- Single request: after reset, req=16'h0001 → at the next cycle grant_idx=0, grant=16'h0001, grant_valid=1; timeout stays 0.
- Full rotation: req=16'hFFFF, done pulsed in every GRANT cycle → owners 0,1,…,15,0 with exactly one zero cycle between each.
- Wrap-around: grant requester 13 and release, so ptr=14; then req=16'h8003 → order 15, 0, 1.
- Hold limit: MAX_HOLD=8, req=16'h0010 held, done=0 → grant=16'h0010 for 8 cycles, then grant=0 with timeout=1 for one cycle, then re-granted to 4.
- Coincident exit: MAX_HOLD=4, done=1 in the 4th GRANT cycle → release with timeout=0.
- Reset mid-grant: owner 9 active, rst=1 for one cycle → next cycle all outputs 0. Then req=16'h8001 → grant_idx=0, because ptr was reset.
